// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: data-memory request/acknowledge bus between the pipeline controller and data memory
interface pipe_ctrl_if;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    modport master (output dmem_req, dmem_we, input dmem_ack);
    modport slave  (input dmem_req, dmem_we, output dmem_ack);
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard control with data-memory wait/timeout sequencing and stall statistics
module pipe_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               MemAccess_M,
    input  logic               MemWrite_M,
    input  logic [4:0]         Rs1_D,
    input  logic [4:0]         Rs2_D,
    input  logic [4:0]         RD_addr_E,
    input  logic [1:0]         ResultSrc_E,
    input  logic               PCSrc_E,
    pipe_ctrl_if.master        dmem,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               StallM,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushW,
    output logic               mem_err,
    output logic [15:0]        stall_cnt
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [7:0]  wcnt;
    logic        err_q;
    logic [15:0] cnt_q;
    logic        idle, timeout, mem_stall, load_use, branch, lu_stall;

    // Memory sequencing, hazard detection and priority resolution; all outputs are zeroed while in reset
    always_comb begin
        idle      = state == IDLE;
        timeout   = !idle && !dmem.dmem_ack && wcnt == 8'(TIMEOUT - 1);
        mem_stall = idle ? MemAccess_M && !dmem.dmem_ack : !dmem.dmem_ack && !timeout;
        load_use  = ResultSrc_E == 2'b01 && RD_addr_E != 5'd0 && (Rs1_D == RD_addr_E || Rs2_D == RD_addr_E);
        branch    = !mem_stall && !timeout && PCSrc_E;
        lu_stall  = !mem_stall && !timeout && !PCSrc_E && load_use;
        dmem.dmem_req = nRST && (idle ? MemAccess_M : !timeout);
        dmem.dmem_we  = dmem.dmem_req && MemWrite_M;
        StallF    = nRST && (mem_stall || lu_stall);
        StallD    = StallF;
        StallE    = nRST && mem_stall;
        StallM    = StallE;
        FlushD    = nRST && branch;
        FlushE    = nRST && (branch || lu_stall);
        FlushW    = nRST && (mem_stall || timeout);
        mem_err   = nRST && err_q;
        stall_cnt = nRST ? cnt_q : 16'd0;
    end

    // Memory FSM, wait counter, sticky timeout flag and saturating front-end stall counter
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            wcnt  <= 8'd0;
            err_q <= 1'b0;
            cnt_q <= 16'd0;
        end else begin
            if (StallF && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
            if (idle) begin
                if (MemAccess_M && !dmem.dmem_ack) begin
                    state <= WAIT;
                    wcnt  <= 8'd1;
                end
            end else if (dmem.dmem_ack || timeout) begin
                state <= IDLE;
                wcnt  <= 8'd0;
                if (timeout)
                    err_q <= 1'b1;
            end else begin
                wcnt <= wcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenario checks of pipe_ctrl with TIMEOUT=4
module tb_pipe_ctrl;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        MemAccess_M, MemWrite_M, PCSrc_E;
    logic [4:0]  Rs1_D, Rs2_D, RD_addr_E;
    logic [1:0]  ResultSrc_E;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [15:0] stall_cnt;
    logic [8:0]  outs;
    int          passed = 0;
    int          total = 0;

    pipe_ctrl_if bus();

    pipe_ctrl #(.TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST), .MemAccess_M(MemAccess_M), .MemWrite_M(MemWrite_M),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_addr_E(RD_addr_E), .ResultSrc_E(ResultSrc_E),
        .PCSrc_E(PCSrc_E), .dmem(bus.master), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
        .FlushW(FlushW), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // {req, we, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    assign outs = {bus.dmem_req, bus.dmem_we, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    task automatic clr();
        MemAccess_M = 0; MemWrite_M = 0; PCSrc_E = 0; bus.dmem_ack = 0;
        Rs1_D = 0; Rs2_D = 0; RD_addr_E = 0; ResultSrc_E = 2'b00;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRST = 0; MemAccess_M = 1; MemWrite_M = 1; PCSrc_E = 1;
        ResultSrc_E = 2'b01; RD_addr_E = 5; Rs2_D = 5;
        #2;
        total++; if (outs !== 9'b0) $display("FAIL reset_outs got %b exp %b", outs, 9'b0); else passed++;
        @(negedge CLK); #2;
        total++; if (outs !== 9'b0) $display("FAIL reset_outs2 got %b exp %b", outs, 9'b0); else passed++;
        total++; if (mem_err !== 1'b0) $display("FAIL reset_err got %b exp 0", mem_err); else passed++;
        total++; if (stall_cnt !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", stall_cnt); else passed++;
        @(negedge CLK);
        clr(); nRST = 1;
        #2;
        total++; if (outs !== 9'b0) $display("FAIL idle_outs got %b exp %b", outs, 9'b0); else passed++;
    endtask

    task automatic test_zero_wait();
        @(negedge CLK);
        MemAccess_M = 1; bus.dmem_ack = 1;
        #2;
        total++; if (outs !== 9'b100000000) $display("FAIL zw_outs got %b exp %b", outs, 9'b100000000); else passed++;
        @(negedge CLK);
        clr();
        #2;
        total++; if (outs !== 9'b0) $display("FAIL zw_after got %b exp %b", outs, 9'b0); else passed++;
        total++; if (stall_cnt !== 16'd0) $display("FAIL zw_cnt got %0d exp 0", stall_cnt); else passed++;
    endtask

    task automatic test_store_wait();
        logic [8:0] exp_v [4] = '{9'b111111001, 9'b111111001, 9'b111111001, 9'b110000000};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            MemAccess_M = 1; MemWrite_M = 1; bus.dmem_ack = (i == 3);
            #2;
            total++; if (outs !== exp_v[i]) $display("FAIL store_c%0d got %b exp %b", i, outs, exp_v[i]); else passed++;
        end
        @(negedge CLK);
        clr();
        #2;
        total++; if (outs !== 9'b0) $display("FAIL store_after got %b exp %b", outs, 9'b0); else passed++;
        total++; if (stall_cnt !== 16'd3) $display("FAIL store_cnt got %0d exp 3", stall_cnt); else passed++;
    endtask

    task automatic test_timeout();
        logic [8:0] exp_v [4] = '{9'b101111001, 9'b101111001, 9'b101111001, 9'b000000001};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            MemAccess_M = 1; bus.dmem_ack = 0;
            #2;
            total++; if (outs !== exp_v[i]) $display("FAIL tmo_c%0d got %b exp %b", i, outs, exp_v[i]); else passed++;
        end
        total++; if (mem_err !== 1'b0) $display("FAIL tmo_err_early got %b exp 0", mem_err); else passed++;
        @(negedge CLK);
        clr();
        #2;
        total++; if (mem_err !== 1'b1) $display("FAIL tmo_err got %b exp 1", mem_err); else passed++;
        total++; if (outs !== 9'b0) $display("FAIL tmo_after got %b exp %b", outs, 9'b0); else passed++;
        total++; if (stall_cnt !== 16'd6) $display("FAIL tmo_cnt got %0d exp 6", stall_cnt); else passed++;
    endtask

    task automatic test_load_use();
        @(negedge CLK);
        ResultSrc_E = 2'b01; RD_addr_E = 5; Rs2_D = 5; Rs1_D = 0;
        #2;
        total++; if (outs !== 9'b001100010) $display("FAIL lu_rs2 got %b exp %b", outs, 9'b001100010); else passed++;
        @(negedge CLK);
        RD_addr_E = 0;
        #2;
        total++; if (outs !== 9'b0) $display("FAIL lu_rd0 got %b exp %b", outs, 9'b0); else passed++;
        total++; if (stall_cnt !== 16'd7) $display("FAIL lu_cnt got %0d exp 7", stall_cnt); else passed++;
        @(negedge CLK);
        RD_addr_E = 5; Rs1_D = 5; Rs2_D = 3;
        #2;
        total++; if (outs !== 9'b001100010) $display("FAIL lu_rs1 got %b exp %b", outs, 9'b001100010); else passed++;
        @(negedge CLK);
        ResultSrc_E = 2'b00;
        #2;
        total++; if (outs !== 9'b0) $display("FAIL lu_alu got %b exp %b", outs, 9'b0); else passed++;
        total++; if (stall_cnt !== 16'd8) $display("FAIL lu_cnt2 got %0d exp 8", stall_cnt); else passed++;
    endtask

    task automatic test_branch();
        @(negedge CLK);
        clr(); PCSrc_E = 1; ResultSrc_E = 2'b01; RD_addr_E = 7; Rs1_D = 7;
        #2;
        total++; if (outs !== 9'b000000110) $display("FAIL br_lu got %b exp %b", outs, 9'b000000110); else passed++;
        @(negedge CLK);
        clr();
        #2;
        total++; if (stall_cnt !== 16'd8) $display("FAIL br_cnt got %0d exp 8", stall_cnt); else passed++;
    endtask

    task automatic test_branch_wait();
        logic [8:0] exp_v [3] = '{9'b101111001, 9'b101111001, 9'b100000110};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            MemAccess_M = 1; PCSrc_E = 1; bus.dmem_ack = (i == 2);
            #2;
            total++; if (outs !== exp_v[i]) $display("FAIL brw_c%0d got %b exp %b", i, outs, exp_v[i]); else passed++;
        end
        @(negedge CLK);
        clr();
        #2;
        total++; if (stall_cnt !== 16'd10) $display("FAIL brw_cnt got %0d exp 10", stall_cnt); else passed++;
    endtask

    task automatic test_reset_wait();
        @(negedge CLK);
        MemAccess_M = 1; bus.dmem_ack = 0;
        #2;
        total++; if (outs !== 9'b101111001) $display("FAIL rw_c0 got %b exp %b", outs, 9'b101111001); else passed++;
        @(negedge CLK);
        nRST = 0;
        #2;
        total++; if (outs !== 9'b0) $display("FAIL rw_inrst got %b exp %b", outs, 9'b0); else passed++;
        @(negedge CLK);
        nRST = 1; MemAccess_M = 0;
        #2;
        total++; if (outs !== 9'b0) $display("FAIL rw_idle got %b exp %b", outs, 9'b0); else passed++;
        total++; if (mem_err !== 1'b0) $display("FAIL rw_err got %b exp 0", mem_err); else passed++;
        total++; if (stall_cnt !== 16'd0) $display("FAIL rw_cnt got %0d exp 0", stall_cnt); else passed++;
    endtask

    initial begin
        clr();
        nRST = 0;
        test_reset();
        test_zero_wait();
        test_store_wait();
        test_timeout();
        test_load_use();
        test_branch();
        test_branch_wait();
        test_reset_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
